// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: 2-flop sync, tick-sampled window with
// hysteresis, press/release/long-press pulses. Optional auto-repeat: AUTO_REPEAT_EN.
module btn_debounce_multi #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 1000,
  parameter int N_SAMPLE     = 8,
  parameter int LONG_TICKS   = 50000,
  parameter int REPEAT_TICKS = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
`ifdef AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
`endif

  if (TICK_DIV < 2 || N_SAMPLE < 2 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("btn_debounce_multi: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Shared sample-tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= {TICK_W{1'b0}};
    end else if (w_tick) begin
      r_tick_cnt <= {TICK_W{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_ONE;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic                r_sync1, r_sync2;
    logic [N_SAMPLE-1:0] r_win;
    logic                r_level, r_press, r_release, r_long;
    state_t              r_state, w_state_nxt;
    logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
    logic                w_level_nxt, w_rise, w_fall, w_press_nxt, w_long_nxt;
`ifdef AUTO_REPEAT_EN
    logic [RPT_W-1:0]    r_rpt, w_rpt_nxt;
`endif

    // Synchroniser and tick-gated sample window
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_win   <= {N_SAMPLE{1'b0}};
      end else begin
        r_sync1 <= i_btn[g];
        r_sync2 <= r_sync1;
        if (w_tick) begin
          r_win <= {r_win[N_SAMPLE-2:0], r_sync2};
        end
      end
    end

    // Hysteresis: only a uniform window may move the level
    always_comb begin
      w_level_nxt = r_level;
      if (&r_win) begin
        w_level_nxt = 1'b1;
      end else if (~|r_win) begin
        w_level_nxt = 1'b0;
      end else begin
        w_level_nxt = r_level;
      end
    end

    assign w_rise = w_level_nxt & ~r_level;
    assign w_fall = ~w_level_nxt & r_level;

    // Press-tracking FSM: next state, hold counter and pulse requests
    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_press_nxt = w_rise;
      w_long_nxt  = 1'b0;
`ifdef AUTO_REPEAT_EN
      w_rpt_nxt   = r_rpt;
`endif
      case (r_state)
        ST_IDLE: begin
          w_hold_nxt = {HOLD_W{1'b0}};
          if (w_rise) begin
            w_state_nxt = ST_PRESSED;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          // A fall on the same tick as the long threshold suppresses o_long
          if (w_fall) begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = {HOLD_W{1'b0}};
          end else if (w_tick) begin
            if (r_hold == HOLD_LAST) begin
              w_state_nxt = ST_HELD;
              w_hold_nxt  = HOLD_MAX;
              w_long_nxt  = 1'b1;
`ifdef AUTO_REPEAT_EN
              w_rpt_nxt   = {RPT_W{1'b0}};
`endif
            end else begin
              w_hold_nxt = r_hold + HOLD_ONE;
            end
          end else begin
            w_state_nxt = ST_PRESSED;
          end
        end
        ST_HELD: begin
          if (w_fall) begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = {HOLD_W{1'b0}};
          end
`ifdef AUTO_REPEAT_EN
          else if (w_tick) begin
            if (r_rpt == RPT_LAST) begin
              w_press_nxt = 1'b1;
              w_rpt_nxt   = {RPT_W{1'b0}};
            end else begin
              w_rpt_nxt = r_rpt + RPT_ONE;
            end
          end
`endif
          else begin
            w_state_nxt = ST_HELD;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = {HOLD_W{1'b0}};
        end
      endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= ST_IDLE;
        r_hold    <= {HOLD_W{1'b0}};
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
`ifdef AUTO_REPEAT_EN
        r_rpt     <= {RPT_W{1'b0}};
`endif
      end else begin
        r_state   <= w_state_nxt;
        r_hold    <= w_hold_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_fall;
        r_long    <= w_long_nxt;
`ifdef AUTO_REPEAT_EN
        r_rpt     <= w_rpt_nxt;
`endif
      end
    end

    assign o_level[g]   = r_level;
    assign o_press[g]   = r_press;
    assign o_release[g] = r_release;
    assign o_long[g]    = r_long;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi: directed scenarios plus random
// stimulus, all compared each cycle against a behavioural model.
module tb_btn_debounce_multi;
  localparam int NB  = 4;
  localparam int TD  = 4;
  localparam int NS  = 4;
  localparam int LT  = 8;
  localparam int RT  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] i_btn;
  logic [NB-1:0] o_level, o_press, o_release, o_long;

  int total = 0;
  int bad   = 0;

  btn_debounce_multi #(
    .N_BTN(NB), .TICK_DIV(TD), .N_SAMPLE(NS), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long)
  );

  always #5 clk = ~clk;

  // Reference model: samples taken every TD-th clock after reset, input seen
  // two clocks late, level set by a unanimous window, press timing in ticks.
  logic [NB-1:0] m_level, m_press, m_release, m_long;
  logic [NB-1:0] q_in[$];
  logic [NB-1:0] win[$];
  int  m_n;
  int  ticks[NB];
  bit  active[NB];
  bit  held[NB];
  int  rpt[NB];

  always @(posedge clk or posedge rst) begin
    logic [NB-1:0] sv, newlvl;
    bit tk, all1, all0;
    if (rst) begin
      m_n = 0;
      m_level = '0; m_press = '0; m_release = '0; m_long = '0;
      q_in.delete(); q_in.push_back('0); q_in.push_back('0);
      win.delete();
      for (int j = 0; j < NS; j++) win.push_back('0);
      for (int i = 0; i < NB; i++) begin
        ticks[i] = 0; active[i] = 0; held[i] = 0; rpt[i] = 0;
      end
    end else begin
      m_n++;
      tk = (m_n % TD) == 0;
      sv = q_in.pop_front();
      q_in.push_back(i_btn);
      for (int i = 0; i < NB; i++) begin
        all1 = 1; all0 = 1;
        foreach (win[j]) begin
          if (win[j][i]) all0 = 0; else all1 = 0;
        end
        newlvl[i] = all1 ? 1'b1 : (all0 ? 1'b0 : m_level[i]);
      end
      if (tk) begin
        void'(win.pop_front());
        win.push_back(sv);
      end
      for (int i = 0; i < NB; i++) begin
        m_press[i] = 0; m_release[i] = 0; m_long[i] = 0;
        if (newlvl[i] && !m_level[i]) begin
          m_press[i] = 1; active[i] = 1; held[i] = 0; ticks[i] = 0;
        end else if (!newlvl[i] && m_level[i]) begin
          m_release[i] = 1; active[i] = 0; held[i] = 0;
        end else if (active[i] && !held[i] && tk) begin
          ticks[i]++;
          if (ticks[i] == LT) begin
            m_long[i] = 1; held[i] = 1; rpt[i] = 0;
          end
        end
`ifdef AUTO_REPEAT_EN
        else if (held[i] && tk) begin
          rpt[i]++;
          if (rpt[i] == RT) begin
            m_press[i] = 1; rpt[i] = 0;
          end
        end
`endif
      end
      m_level = newlvl;
    end
  end

  int cyc_n = 0;
  int press_cnt[NB], release_cnt[NB], long_cnt[NB];
  int press_at[NB], long_at[NB], rpt_gap[NB];

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0; release_cnt[i] = 0; long_cnt[i] = 0;
      press_at[i] = 0; long_at[i] = 0; rpt_gap[i] = 0;
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc_n++;
      total++;
      assert ({o_level, o_press, o_release, o_long} === {m_level, m_press, m_release, m_long})
      else begin
        bad++;
        $error("FAIL outputs@%0d: got lvl=%b prs=%b rel=%b lng=%b want lvl=%b prs=%b rel=%b lng=%b",
               cyc_n, o_level, o_press, o_release, o_long, m_level, m_press, m_release, m_long);
      end
      for (int i = 0; i < NB; i++) begin
        if (o_press[i] === 1'b1) begin
          if (long_cnt[i] > 0 && rpt_gap[i] == 0) rpt_gap[i] = cyc_n - long_at[i];
          press_cnt[i]++;
          if (press_cnt[i] == 1) press_at[i] = cyc_n;
        end
        if (o_release[i] === 1'b1) release_cnt[i]++;
        if (o_long[i] === 1'b1) begin
          long_cnt[i]++;
          long_at[i] = cyc_n;
        end
      end
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    total++;
    assert (got == want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic expect_le(input string tag, input int got, input int lim);
    total++;
    assert (got <= lim) else begin
      bad++;
      $error("FAIL %s: got %0d want <= %0d", tag, got, lim);
    end
  endtask

  int lat;

  initial begin
    rst = 1'b0;
    i_btn = '0;
    #1 rst = 1'b1;
    cyc(3);
    total++;
    assert ({o_level, o_press, o_release, o_long} === 16'h0000) else begin
      bad++; $error("FAIL reset_outputs: got %h want 0000", {o_level, o_press, o_release, o_long});
    end
    rst = 1'b0;

    // 1: clean press and release on channel 0
    clear_counts();
    i_btn[0] = 1'b1;
    lat = 0;
    while (o_level[0] !== 1'b1 && lat < 25) begin cyc(1); lat++; end
    expect_le("t1_rise_latency", lat, 19);
    cyc(200);
    i_btn[0] = 1'b0;
    lat = 0;
    while (o_level[0] !== 1'b0 && lat < 25) begin cyc(1); lat++; end
    expect_le("t1_fall_latency", lat, 19);
    cyc(5);
    expect_int("t1_press0", press_cnt[0], 1);
    expect_int("t1_release0", release_cnt[0], 1);
    expect_int("t1_others_press", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // 2: bouncing channel 1, then a short glitch
    clear_counts();
    for (int k = 0; k < 20; k++) begin i_btn[1] = ~i_btn[1]; cyc(3); end
    i_btn[1] = 1'b1;
    cyc(30);
    expect_int("t2_press1", press_cnt[1], 1);
    expect_int("t2_release1", release_cnt[1], 0);
    i_btn[1] = 1'b0;
    cyc(3);
    i_btn[1] = 1'b1;
    cyc(25);
    expect_int("t2_glitch_level1", int'(o_level[1]), 1);
    expect_int("t2_glitch_press1", press_cnt[1], 1);
    expect_int("t2_glitch_release1", release_cnt[1], 0);

    // 3: long press on channel 2
    clear_counts();
    i_btn[2] = 1'b1;
    lat = 0;
    while (press_cnt[2] == 0 && lat < 25) begin cyc(1); lat++; end
    expect_le("t3_press_latency", lat, 19);
    cyc(100);
    expect_int("t3_long_count", long_cnt[2], 1);
    expect_le("t3_long_delay_hi", long_at[2] - press_at[2], 36);
    expect_le("t3_long_delay_lo", 28, long_at[2] - press_at[2]);
`ifdef AUTO_REPEAT_EN
    expect_int("t3_repeat_gap", rpt_gap[2], 12);
`else
    expect_int("t3_no_repeat", press_cnt[2], 1);
`endif
    i_btn[2] = 1'b0;
    cyc(25);

    // 4: short press on channel 3
    clear_counts();
    i_btn[3] = 1'b1;
    lat = 0;
    while (o_level[3] !== 1'b1 && lat < 25) begin cyc(1); lat++; end
    cyc(2);
    i_btn[3] = 1'b0;
    cyc(25);
    expect_int("t4_press3", press_cnt[3], 1);
    expect_int("t4_release3", release_cnt[3], 1);
    expect_int("t4_long3", long_cnt[3], 0);

    // 5: simultaneous presses on channels 0 and 2
    i_btn = '0;
    cyc(30);
    clear_counts();
    i_btn = 4'b0101;
    lat = 0;
    while (o_press === 4'b0000 && lat < 25) begin cyc(1); lat++; end
    expect_int("t5_press_pattern", int'(o_press), 5);
    i_btn = 4'b0001;
    cyc(45);
    expect_int("t5_ch0_long", long_cnt[0], 1);

    // 6: asynchronous reset while channel 0 is held
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    assert ({o_level, o_press, o_release, o_long} === 16'h0000) else begin
      bad++; $error("FAIL async_reset: got %h want 0000", {o_level, o_press, o_release, o_long});
    end
    cyc(3);
    rst = 1'b0;
    clear_counts();
    lat = 0;
    while (o_level[0] !== 1'b1 && lat < 25) begin cyc(1); lat++; end
    expect_le("t6_repress_latency", lat, 19);
    cyc(5);
    expect_int("t6_press0", press_cnt[0], 1);
    expect_int("t6_release0", release_cnt[0], 0);

    // Random stimulus against the model
    for (int k = 0; k < 200; k++) begin
      i_btn = NB'($urandom);
      cyc(int'($urandom_range(1, 40)));
    end
    i_btn = '0;
    cyc(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
